mmio_bridge: RTL
================

// Module: mmio_bridge
// PURPOSE
// - Decodes the datapath data-memory port into three targets: dmem, a buffered console TX channel and a test-status register.
// - Sits between datapath and dmem inside the top level.
// - Generalises the fixed console/test decode to parametrised addresses, a console FIFO with valid/ready drain, and pass/fail status.
// - Back-pressures the CPU with a stall while the FIFO is full.
// PARAMETERS
// - XLEN            32             data/address width
// - CONSOLE_ADDR    32'h1000_0000  console TX data (W), console status (R)
// - TEST_STAT_ADDR  32'h2000_0000  test status word (W), status readback (R)
// - PASS_CODE       123456789      value that signals test pass
// - CONS_DEPTH      8              console FIFO entries; power of 2, >= 2
// PORTS
// - clk            in   1           clock
// - reset          in   1           synchronous, active-high reset
// - cpu_addr       in   XLEN        datapath dmem address
// - cpu_wdata      in   XLEN        datapath store data
// - cpu_we         in   1           datapath store strobe
// - cpu_rdata      out  XLEN        load data returned to datapath
// - cpu_stall      out  1           hold datapath; store not accepted this cycle
// - mem_addr       out  XLEN        dmem address (= cpu_addr)
// - mem_wdata      out  XLEN        dmem write data
// - mem_we         out  1           dmem write enable
// - mem_rdata      in   XLEN        dmem read data
// - console_wdata  out  XLEN        FIFO head word
// - console_valid  out  1           FIFO non-empty
// - console_ready  in   1           consumer accepts head this cycle
// - test_passed    out  1           sticky pass flag
// - test_failed    out  1           sticky fail flag
// - test_code      out  XLEN        first status word written
// BEHAVIOUR
// Reset
// - FIFO empty; console_valid=0; console_wdata=0.
// - test_passed=0, test_failed=0, test_code=0; cycle counter = 0.
// Decode (combinational, exact address match)
// - CONSOLE_ADDR, TEST_STAT_ADDR and (optionally) CYCLE_ADDR/+4 are MMIO.
// - Everything else goes to dmem.
// - mem_we=0 and mem_wdata=0 whenever the address is MMIO or cpu_stall=1.
// Console FIFO
// - Push on cpu_we & CONSOLE_ADDR & !full; word visible on console_wdata the next cycle.
// - Pop on console_valid & console_ready. Order preserved; count in 0..CONS_DEPTH.
// - Pointers are log2(CONS_DEPTH) bits and wrap modulo depth.
// - Full and a console store: cpu_stall=1 (combinational), no push, nothing dropped.
//   - A same-cycle pop does NOT clear the stall; the push lands the following cycle.
// - Empty and a push: no same-cycle bypass; console_valid rises next cycle.
// - Push and pop together when 0<count<DEPTH: count unchanged.
// - Console status read: cpu_rdata = {count in [XLEN-1:8], 6'b0, empty, full}.
// Test status
// - First store to TEST_STAT_ADDR latches test_code.
//   - Value == PASS_CODE: test_passed=1.
//   - Any other value: test_failed=1.
// - Later stores are ignored (first write wins); flags are mutually exclusive.
// - Status read: cpu_rdata = {XLEN-2 zeros, test_failed, test_passed}.
// - cpu_stall only for the console-full case; otherwise 0.
// - Non-MMIO reads: cpu_rdata = mem_rdata (pass-through, no added latency).
// - Reset mid-operation flushes the FIFO contents and clears the test flags.
// CONFIGURATION
// MMIO_CYCLE_COUNTER_EN defined:
// - Adds a 64-bit free-running cycle counter, +1 per cycle, 0 after reset, wraps to 0.
// - CYCLE_ADDR = 32'h3000_0000 reads bits [31:0]; CYCLE_ADDR+4 reads bits [63:32].
// - Stores to either address are discarded and not forwarded to dmem.
// MMIO_CYCLE_COUNTER_EN undefined:
// - No counter; both addresses decode as ordinary dmem.
// TESTING
// 1. Store 'H','i' to CONSOLE_ADDR with console_ready=1.
//    -> console_valid 1 cycle later; 0x48 then 0x69 drained in order; mem_we stays 0.
// 2. console_ready=0; 9 consecutive console stores with CONS_DEPTH=8.
//    -> stores 1-8 accepted, cpu_stall=1 on the 9th.
//    -> raise ready: 9th pushed the cycle after the first pop; status read shows count=8, full=1.
// 3. Store 123456789 to TEST_STAT_ADDR, then store 5.
//    -> test_passed=1, test_failed=0, test_code=123456789 persists.
// 4. After reset, store 7 to TEST_STAT_ADDR.
//    -> test_failed=1, test_code=7; status read returns 32'h2.
// 5. Store 0xDEADBEEF to 0x0000_0100, then load it.
//    -> mem_we=1 for one cycle; cpu_rdata=mem_rdata; no stall.
// 6. Assert reset with 3 words queued.
//    -> console_valid=0 next cycle.
//    -> With MMIO_CYCLE_COUNTER_EN, a load from CYCLE_ADDR N cycles after reset returns N (±1 fixed offset).

Source files
------------

// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge between the datapath data port, dmem, a console TX FIFO and a test-status register.
// Define MMIO_CYCLE_COUNTER_EN to map a free-running 64-bit cycle counter at CYCLE_ADDR / CYCLE_ADDR+4.

// fifo: generic synchronous FIFO with occupancy count.
// Latency: a pushed word appears on pop_dat the cycle after the push (no bypass).
// Backpressure: push_rdy drops when full; pop_dat reads 0 while empty.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    output logic                       push_rdy,
    input  logic [W-1:0]               push_dat,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_vld & pop_rdy;
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// mmio_bridge: exact-match address decode to dmem, console FIFO, test status (and optional cycle counter).
// Latency: combinational decode and read mux; console and status writes take effect next cycle.
// Backpressure: cpu_stall asserts combinationally on a console store while the FIFO is full.
module mmio_bridge #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] CONSOLE_ADDR   = XLEN'(32'h1000_0000),
    parameter logic [XLEN-1:0] TEST_STAT_ADDR = XLEN'(32'h2000_0000),
    parameter logic [XLEN-1:0] PASS_CODE      = XLEN'(123456789),
    parameter int              CONS_DEPTH     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    input  logic            cpu_we,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            cpu_stall,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] console_wdata,
    output logic            console_valid,
    input  logic            console_ready,
    output logic            test_passed,
    output logic            test_failed,
    output logic [XLEN-1:0] test_code
);
    localparam int CW = $clog2(CONS_DEPTH) + 1;

    logic          is_cons;
    logic          is_stat;
    logic          is_mmio;
    logic          cons_push;
    logic          cons_rdy;
    logic          cons_full;
    logic          cons_empty;
    logic [CW-1:0] cons_count;
    logic          stat_locked;

    assign is_cons = (cpu_addr == CONSOLE_ADDR);
    assign is_stat = (cpu_addr == TEST_STAT_ADDR);

`ifdef MMIO_CYCLE_COUNTER_EN
    localparam logic [XLEN-1:0] CYCLE_ADDR = XLEN'(32'h3000_0000);

    logic        is_cyc_lo;
    logic        is_cyc_hi;
    logic [63:0] cycle_cnt;

    assign is_cyc_lo = (cpu_addr == CYCLE_ADDR);
    assign is_cyc_hi = (cpu_addr == CYCLE_ADDR + XLEN'(4));
    assign is_mmio   = is_cons | is_stat | is_cyc_lo | is_cyc_hi;

    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 64'd1;
    end
`else
    assign is_mmio = is_cons | is_stat;
`endif

    // A pop in the same cycle does not relieve a full FIFO; the stalled store retries next cycle.
    assign cons_full  = ~cons_rdy;
    assign cons_empty = ~console_valid;
    assign cpu_stall  = cpu_we & is_cons & cons_full;
    assign cons_push  = cpu_we & is_cons;

    assign mem_addr  = cpu_addr;
    assign mem_we    = cpu_we & ~is_mmio & ~cpu_stall;
    assign mem_wdata = mem_we ? cpu_wdata : '0;

    fifo #(
        .W     (XLEN),
        .DEPTH (CONS_DEPTH)
    ) u_cons_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (cons_push),
        .push_rdy (cons_rdy),
        .push_dat (cpu_wdata),
        .pop_vld  (console_valid),
        .pop_rdy  (console_ready),
        .pop_dat  (console_wdata),
        .count    (cons_count)
    );

    // First store wins; the flags are decided once and then frozen until reset.
    assign stat_locked = test_passed | test_failed;

    always_ff @(posedge clk) begin
        if (reset) begin
            test_passed <= 1'b0;
            test_failed <= 1'b0;
            test_code   <= '0;
        end else if (cpu_we && is_stat && !stat_locked) begin
            test_code   <= cpu_wdata;
            test_passed <= (cpu_wdata == PASS_CODE);
            test_failed <= (cpu_wdata != PASS_CODE);
        end
    end

    always_comb begin
        cpu_rdata = mem_rdata;
        if (is_cons) begin
            cpu_rdata = {{(XLEN-8-CW){1'b0}}, cons_count, 6'b0, cons_empty, cons_full};
        end else if (is_stat) begin
            cpu_rdata = {{(XLEN-2){1'b0}}, test_failed, test_passed};
        end
`ifdef MMIO_CYCLE_COUNTER_EN
        else if (is_cyc_lo) begin
            cpu_rdata = XLEN'(cycle_cnt[31:0]);
        end else if (is_cyc_hi) begin
            cpu_rdata = XLEN'(cycle_cnt[63:32]);
        end
`endif
    end
endmodule
